// File: rtl/shift_defs.sv
// Shared op and state encodings for the shift sequencer and ALU decode.
// Also holds the step-counter width.
package shift_defs;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHRA = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step on {z_high,z_low}.
// Only SHL carries bits into the high half.
import shift_defs::*;

module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] z_in,
  output logic [2*WIDTH-1:0] z_out
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_zero;

  assign w_lo   = z_in[WIDTH-1:0];
  assign w_zero = '0;

  always_comb begin
    z_out = z_in;
    case (op)
      OP_SHL:  z_out = z_in << 1;
      OP_SHR:  z_out = {w_zero, 1'b0, w_lo[WIDTH-1:1]};
      OP_SHRA: z_out = {w_zero, w_lo[WIDTH-1], w_lo[WIDTH-1:1]};
      OP_ROL:  z_out = {w_zero, w_lo[WIDTH-2:0], w_lo[WIDTH-1]};
      OP_ROR:  z_out = {w_zero, w_lo[0], w_lo[WIDTH-1:1]};
      default: z_out = z_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one bit per clock, counted down from shamt[4:0].
// done pulses the cycle after the DONE state.
import shift_defs::*;

module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high
);

  state_e             r_state;
  logic [2:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_zl;
  logic [WIDTH-1:0]   r_zh;
  logic               r_done;

  logic [CNT_W-1:0]   w_n;
  logic [2*WIDTH-1:0] w_next;
  logic               w_unused_shamt;

  assign w_unused_shamt = ^shamt[WIDTH-1:CNT_W];

  // Reserved ops complete with no steps.
  assign w_n = op_valid(op) ? shamt[CNT_W-1:0] : '0;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op    (r_op),
    .z_in  ({r_zh, r_zl}),
    .z_out (w_next)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_zl    <= '0;
      r_zh    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_zl    <= operand;
            r_zh    <= '0;
            r_cnt   <= w_n;
            r_state <= (w_n != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          {r_zh, r_zl} <= w_next;
          r_cnt        <= r_cnt - 1'b1;
          if (r_cnt == 5'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign z_low  = r_zl;
  assign z_high = r_zh;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed ops push expected
// results; a negedge monitor pops on done and checks value and latency.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [31:0] shamt;
  logic        busy;
  logic        done;
  logic [31:0] z_low;
  logic [31:0] z_high;

  typedef struct {
    logic [31:0] zl;
    logic [31:0] zh;
    int          edge_n;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  shift_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .z_low   (z_low),
    .z_high  (z_high)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (clr && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("z_low", z_low, e.zl);
        chk("z_high", z_high, e.zh);
        chk("latency", 32'(cyc), 32'(e.edge_n));
        chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the done negedge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] ezl,
                        input logic [31:0] ezh, input int n,
                        input bit repulse);
    exp_t e;
    int   k;
    op      = o;
    operand = a;
    shamt   = s;
    start   = 1'b1;
    e.zl     = ezl;
    e.zh     = ezh;
    e.edge_n = cyc + 1 + n + 1;
    q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    op      = 3'($urandom_range(0, 4));
    operand = $urandom;
    shamt   = $urandom;
    k = 0;
    while (!done && k < 60) begin
      start = (repulse && k == 2);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%b, expected 1 within 60 cycles", done);
      q.delete();
    end
  endtask

  initial begin
    clr     = 1'b0;
    start   = 1'b0;
    op      = '0;
    operand = 32'hDEAD_BEEF;
    shamt   = 32'd5;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_z_low", z_low, 32'd0);
    chk("rst_z_high", z_high, 32'd0);
    clr = 1'b1;

    run_op(3'd0, 32'h0001_5555, 32'd7, 32'h00AA_AA80, 32'h0, 7, 1'b0);
    run_op(3'd0, 32'hAAA0_0000, 32'd7, 32'h5000_0000, 32'h55, 7, 1'b0);
    run_op(3'd2, 32'h8000_0010, 32'd4, 32'hF800_0001, 32'h0, 4, 1'b0);
    run_op(3'd4, 32'h0000_FFFF, 32'd8, 32'hFF00_00FF, 32'h0, 8, 1'b0);
    run_op(3'd3, 32'h8000_0001, 32'd31, 32'hC000_0000, 32'h0, 31, 1'b0);
    run_op(3'd3, 32'h8000_0001, 32'h20, 32'h8000_0001, 32'h0, 0, 1'b0);
    run_op(3'd1, 32'hF000_0000, 32'd4, 32'h0F00_0000, 32'h0, 4, 1'b0);
    run_op(3'd5, 32'h1234_5678, 32'd9, 32'h1234_5678, 32'h0, 0, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 32'h7FFF_FFFF, 31, 1'b0);
    run_op(3'd0, 32'h0001_5555, 32'hFFFF_FF07, 32'h00AA_AA80, 32'h0, 7, 1'b0);
    run_op(3'd0, 32'h0001_5555, 32'd7, 32'h00AA_AA80, 32'h0, 7, 1'b1);

    // Abort a 7-step SHL mid-flight with an asynchronous clear.
    op      = 3'd0;
    operand = 32'h0001_5555;
    shamt   = 32'd7;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_mid", {31'b0, busy}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_done", {31'b0, done}, 32'd0);
    chk("clr_z_low", z_low, 32'd0);
    chk("clr_z_high", z_high, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    run_op(3'd0, 32'hAAA0_0000, 32'd7, 32'h5000_0000, 32'h55, 7, 1'b0);
    @(negedge clk);
    chk("hold_z_low", z_low, 32'h5000_0000);
    chk("hold_z_high", z_high, 32'h55);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3 bits: 0 SHL, 1 SHR, 2 SHRA, 3 ROL, 4 ROR; 5-7 reserved.
REQ-006 SHALL have port operand, input, WIDTH bits: the value to shift.
REQ-007 SHALL have port shamt, input, WIDTH bits: the shift count; only shamt[4:0] is used, upper bits ignored.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port z_low, output, WIDTH bits: the primary result.
REQ-011 SHALL have port z_high, output, WIDTH bits: bits shifted out (SHL only), else 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at a rising edge (acceptance edge E0): SHALL latch op, operand and shamt[4:0] into internal registers, clear z_high, load the counter with N=shamt[4:0], then go to SHIFT if N>0, else DONE.
REQ-014 SHIFT SHALL perform exactly one 1-bit step per clock and decrement the counter; on the edge that performs the last step, SHALL go to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 Latency: done SHALL be high in the cycle after edge E(N+1); N=0 gives done after E1.
REQ-017 SHL step: SHALL compute {z_high,z_low} <= {z_high,z_low} << 1 with zero fill, so z_high holds the overflow bits.
REQ-018 SHR step: SHALL shift right 1 with zero fill.
REQ-019 SHRA step: SHALL shift right 1, replicating the MSB.
REQ-020 ROL/ROR step: SHALL rotate 1 bit within z_low.
REQ-021 For SHR, SHRA, ROL and ROR, z_high SHALL remain 0.
REQ-022 Reserved op SHALL be treated as N=0: z_low=operand, z_high=0, done after E1.
REQ-023 start while busy SHALL be ignored, with no effect on the in-flight operation or the latched inputs.
REQ-024 start high in the DONE cycle SHALL be ignored; a new start SHALL be accepted from IDLE only, so back-to-back ops are spaced at minimum N+2 cycles.
REQ-025 Changes to operand, op or shamt after E0 SHALL NOT affect the result.
REQ-026 z_low and z_high SHALL be valid when done=1 and SHALL hold until the next accepted start.
REQ-027 Intermediate values during SHIFT are visible but undefined for use.

Reset
REQ-028 clr=0 SHALL force state IDLE immediately, asynchronously, including mid-SHIFT.
REQ-029 During reset, busy, done, z_low, z_high and the counter SHALL all be 0.
REQ-030 After clr rises, the first start SHALL be accepted on the first rising edge where start=1.

Structure
REQ-031 The op encodings (SHL..ROR) and the state encodings SHALL live in a shared package shift_defs, reused by the ALU decode.
REQ-032 The block SHALL use one sub-module, shift_step: combinational single-bit step taking op and {z_high,z_low}, returning the next {z_high,z_low}.
REQ-033 The counter SHALL be 5 bits wide.

Verification
REQ-034 SHL, operand 0x00015555, shamt 7: SHALL give z_low 0x00AAAA80 and z_high 0, with done 8 edges after E0.
REQ-035 SHL, operand 0xAAA00000, shamt 7: SHALL give z_low 0x50000000 and z_high 0x00000055.
REQ-036 SHRA, operand 0x80000010, shamt 4: SHALL give z_low 0xF8000001; ROR, operand 0x0000FFFF, shamt 8: SHALL give z_low 0xFF0000FF.
REQ-037 ROL, operand 0x80000001, shamt 31: SHALL give z_low 0xC0000000 after 32 edges; shamt 0x00000020 (count 0): SHALL give z_low=operand with done after E1.
REQ-038 start re-pulsed at cycle 3 of a 7-step SHL: SHALL be ignored, with the original result unchanged.
REQ-039 clr low at cycle 3 of a 7-step SHL: SHALL immediately give busy=0 and outputs 0, and the next start SHALL be accepted normally.
